// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT.
// Issues butterflies per stage and delays their write-back addresses by BF_LAT cycles.
module fft_stage_sequencer #(
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       hold,
    output logic                       rd_valid,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           tw_addr,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = LOG2N;
    localparam int JW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [SW-1:0] s, s_n;
    logic [JW-1:0] j, j_n;
    logic [3:0]    dcnt, dcnt_n;
    logic          issue;

    logic [AW-1:0] jx, span, pos, grp, addr_a, addr_b;
    logic [SW-1:0] tw_sh;

    logic          pv [BF_LAT];
    logic [AW-1:0] pa [BF_LAT];
    logic [AW-1:0] pb [BF_LAT];

    always_comb begin
        jx     = AW'(j);
        span   = AW'(1) << s;
        pos    = jx & (span - AW'(1));
        grp    = jx >> s;
        addr_a = ((grp << s) << 1) | pos;
        addr_b = addr_a + span;
        tw_sh  = SW'(LOG2N - 1) - s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            s     <= '0;
            j     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            j     <= j_n;
            dcnt  <= dcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        j_n     = j;
        dcnt_n  = dcnt;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    s_n     = '0;
                    j_n     = '0;
                end
            end
            RUN: begin
                if (!hold) begin
                    issue = 1'b1;
                    j_n   = j + JW'(1);
                    if (j == '1) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end
                end
            end
            DRAIN: begin
                // Fixed-latency datapath: BF_LAT cycles after the last issue its write is out.
                if (dcnt == 4'(BF_LAT - 1)) begin
                    if (s == SW'(LOG2N - 1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        s_n     = s + SW'(1);
                        j_n     = '0;
                    end
                end else begin
                    dcnt_n = dcnt + 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid  <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            stage     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= issue;
            busy     <= (state != IDLE);
            done     <= (state == DONE);
            if (issue) begin
                rd_addr_a <= addr_a;
                rd_addr_b <= addr_b;
                tw_addr   <= JW'(pos << tw_sh);
                stage     <= s;
            end
        end
    end

    // Write-back delay line shifts unconditionally so latency stays fixed under hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < BF_LAT; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
                pb[i] <= '0;
            end
        end else begin
            pv[0] <= rd_valid;
            pa[0] <= rd_addr_a;
            pb[0] <= rd_addr_b;
            for (int unsigned i = 1; i < BF_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    assign wr_en     = pv[BF_LAT-1];
    assign wr_addr_a = pa[BF_LAT-1];
    assign wr_addr_b = pb[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: cycle-window vectors and spot addresses
// at BF_LAT=2, plus BF_LAT=1 and BF_LAT=8 instances sharing the same inputs.
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;

    logic       rd_valid, wr_en, busy, done;
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_addr;
    logic [1:0] stage;

    logic       l1_rv, l1_we, l1_by, l1_dn;
    logic [3:0] l1_ra, l1_rb, l1_wa, l1_wb;
    logic [2:0] l1_tw;
    logic [1:0] l1_st;
    logic       l8_rv, l8_we, l8_by, l8_dn;
    logic [3:0] l8_ra, l8_rb, l8_wa, l8_wb;
    logic [2:0] l8_tw;
    logic [1:0] l8_st;

    int checks = 0;
    int failures = 0;

    logic [127:0] v_rv, v_we, v_dn, v_by, v_rv1, v_we1, v_dn1, v_rv8, v_we8, v_dn8;
    logic [3:0]   c_ra [128];
    logic [3:0]   c_rb [128];
    logic [3:0]   c_wa [128];
    logic [3:0]   c_wb [128];
    logic [2:0]   c_tw [128];
    logic [1:0]   c_st [128];

    always #5 clk = ~clk;

    fft_stage_sequencer #(.LOG2N(4), .BF_LAT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold),
        .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .stage(stage), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .busy(busy), .done(done)
    );

    fft_stage_sequencer #(.LOG2N(4), .BF_LAT(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold),
        .rd_valid(l1_rv), .rd_addr_a(l1_ra), .rd_addr_b(l1_rb),
        .tw_addr(l1_tw), .stage(l1_st), .wr_en(l1_we),
        .wr_addr_a(l1_wa), .wr_addr_b(l1_wb), .busy(l1_by), .done(l1_dn)
    );

    fft_stage_sequencer #(.LOG2N(4), .BF_LAT(8)) dut_l8 (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold),
        .rd_valid(l8_rv), .rd_addr_a(l8_ra), .rd_addr_b(l8_rb),
        .tw_addr(l8_tw), .stage(l8_st), .wr_en(l8_we),
        .wr_addr_a(l8_wa), .wr_addr_b(l8_wb), .busy(l8_by), .done(l8_dn)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // cnt windows of len consecutive set bits, starting at base and repeating every period
    function automatic logic [127:0] win(input int base, input int period, input int len, input int cnt);
        logic [127:0] v = '0;
        for (int k = 0; k < cnt; k++)
            for (int i = 0; i < len; i++)
                if (base + k * period + i < 128) v[base + k * period + i] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] bit1(input int idx);
        logic [127:0] v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Cycle c of the capture is the state right after the edge that samples ssched[c]/hsched[c].
    task automatic capture(input int ncyc, input logic [127:0] ssched, input logic [127:0] hsched);
        v_rv = '0; v_we = '0; v_dn = '0; v_by = '0;
        v_rv1 = '0; v_we1 = '0; v_dn1 = '0; v_rv8 = '0; v_we8 = '0; v_dn8 = '0;
        for (int c = 0; c < ncyc; c++) begin
            start = ssched[c];
            hold  = hsched[c];
            @(posedge clk);
            #1;
            v_rv[c] = rd_valid; v_we[c] = wr_en; v_dn[c] = done; v_by[c] = busy;
            v_rv1[c] = l1_rv; v_we1[c] = l1_we; v_dn1[c] = l1_dn;
            v_rv8[c] = l8_rv; v_we8[c] = l8_we; v_dn8[c] = l8_dn;
            c_ra[c] = rd_addr_a; c_rb[c] = rd_addr_b; c_tw[c] = tw_addr;
            c_st[c] = stage; c_wa[c] = wr_addr_a; c_wb[c] = wr_addr_b;
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic check_nominal(input string pfx);
        check({pfx, "_rd_valid"}, v_rv, win(1, 10, 8, 4));
        check({pfx, "_wr_en"},    v_we, win(3, 10, 8, 4));
        check({pfx, "_done"},     v_dn, bit1(41));
    endtask

    initial begin
        logic [127:0] sch;
        logic [127:0] hsch;

        #2;
        check("reset_outputs", {rd_valid, wr_en, busy, done, stage, rd_addr_a, rd_addr_b,
                                tw_addr, wr_addr_a, wr_addr_b}, '0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", {rd_valid, wr_en, busy, done}, '0);

        // Nominal transform, all three latencies
        capture(100, bit1(0), '0);
        check_nominal("nom");
        check("nom_busy", v_by, win(1, 1, 41, 1));
        check("nom_idle_c42", {v_by[42], v_rv[42]}, 2'b00);
        check("s0j0", {c_ra[1], c_rb[1], c_tw[1]}, {4'd0, 4'd1, 3'd0});
        check("s1j1", {c_ra[12], c_rb[12], c_tw[12]}, {4'd1, 4'd3, 3'd4});
        check("s2j6", {c_ra[27], c_rb[27], c_tw[27]}, {4'd10, 4'd14, 3'd4});
        check("s3j5", {c_ra[36], c_rb[36], c_tw[36]}, {4'd5, 4'd13, 3'd5});
        check("wr_s2j6", {c_wa[29], c_wb[29]}, {4'd10, 4'd14});
        check("wr_s3j5", {c_wa[38], c_wb[38]}, {4'd5, 4'd13});
        check("stage_c10_c11", {c_st[10], c_st[11]}, {2'd0, 2'd1});
        check("stage_c21_c31", {c_st[21], c_st[31]}, {2'd2, 2'd3});
        check("lat1_rd_valid", v_rv1, win(1, 9, 8, 4));
        check("lat1_wr_en",    v_we1, win(2, 9, 8, 4));
        check("lat1_done",     v_dn1, bit1(37));
        check("lat8_rd_valid", v_rv8, win(1, 16, 8, 4));
        check("lat8_wr_en",    v_we8, win(9, 16, 8, 4));
        check("lat8_done",     v_dn8, bit1(65));

        // Hold for cycles 4-6 of stage 0
        capture(100, bit1(0), win(4, 1, 3, 1));
        check("hold_rd_valid", v_rv, win(1, 1, 3, 1) | win(7, 1, 5, 1) | win(14, 10, 8, 3));
        check("hold_wr_en", v_we, win(3, 1, 3, 1) | win(9, 1, 5, 1) | win(16, 10, 8, 3));
        check("hold_j3_addr", {c_ra[7], c_rb[7], c_tw[7]}, {4'd6, 4'd7, 3'd0});
        check("hold_done", v_dn, bit1(44));
        check("hold_busy", v_by, win(1, 1, 44, 1));

        // Hold on the last issue of stage 0, plus holds in DRAIN and DONE that must be ignored
        hsch = bit1(8) | bit1(10) | bit1(11) | bit1(42);
        capture(100, bit1(0), hsch);
        check("holdlast_rd_valid", v_rv, win(1, 1, 7, 1) | bit1(9) | win(12, 10, 8, 3));
        check("holdlast_wr_en", v_we, win(3, 1, 7, 1) | bit1(11) | win(14, 10, 8, 3));
        check("holdlast_j7_wr", {c_wa[11], c_wb[11]}, {4'd14, 4'd15});
        check("holdlast_done", v_dn, bit1(42));

        // Ignored start pulses in RUN, DRAIN and DONE
        sch = bit1(0) | bit1(5) | bit1(20) | bit1(41);
        capture(100, sch, '0);
        check_nominal("ign");

        // Start held high from the DONE cycle
        sch = bit1(0) | win(41, 1, 3, 1);
        capture(100, sch, '0);
        check("held_rd_valid", v_rv, win(1, 10, 8, 4) | win(43, 10, 8, 4));
        check("held_done", v_dn, bit1(41) | bit1(83));

        // Asynchronous reset in stage 2 with writes in flight
        capture(25, bit1(0), '0);
        check("pre_reset_wr_en", {v_we[24], c_st[24]}, {1'b1, 2'd2});
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {rd_valid, wr_en, busy, done, stage, rd_addr_a, rd_addr_b,
                                      tw_addr, wr_addr_a, wr_addr_b}, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("in_reset_quiet", {wr_en, rd_valid, busy, done}, '0);
        end
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {wr_en, rd_valid, busy, done}, '0);
        capture(100, bit1(0), '0);
        check_nominal("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequences one in-place radix-2 DIT FFT over an N-point buffer. For each butterfly it generates the buffer read addresses, the twiddle ROM address for the cosine/sine/combined-coefficient ROMs, and delayed write-back addresses matched to a fixed-latency butterfly datapath. It sits between the top-level control, which issues `start` and observes `done`, and the butterfly datapath, sample RAM and twiddle ROMs. It drains the datapath between stages so no stage reads a word the previous stage has not yet written.

## Interface
- `LOG2N`, 4: log2 of FFT size. N = 16, 8 butterflies per stage, 4 stages.
- `BF_LAT`, 2: cycles from read-address issue to write-back. Legal range is 1..8.

- `clk` input, 1 bit: single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a transform. Sampled only in IDLE.
- `hold` input, 1 bit: datapath not ready. Freezes issue in RUN only.
- `rd_valid` output, 1 bit: a butterfly is issued this cycle.
- `rd_addr_a` output, LOG2N bits: upper-leg read address.
- `rd_addr_b` output, LOG2N bits: lower-leg read address.
- `tw_addr` output, LOG2N-1 bits: twiddle ROM address (3 bits at defaults).
- `stage` output, clog2(LOG2N) bits: current stage, 0..LOG2N-1.
- `wr_en` output, 1 bit: write back butterfly results.
- `wr_addr_a` output, LOG2N bits: write address for the A leg.
- `wr_addr_b` output, LOG2N bits: write address for the B leg.
- `busy` output, 1 bit: high whenever state is not IDLE.
- `done` output, 1 bit: one-cycle pulse when the transform is complete.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when `start`=1. Clear the stage counter s and the butterfly counter j.
  - RUN: each cycle with `hold`=0, issue butterfly (s, j), then increment j. After issuing j = N/2-1, go to DRAIN.
  - RUN with `hold`=1: no issue, `rd_valid`=0, counters frozen.
  - DRAIN: wait until the last write of stage s has been emitted. Then, if s < LOG2N-1: s++, j=0, go to RUN. Otherwise go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- **Address arithmetic** (unsigned, LOG2N bits):
  - span = 1<<s, grp = j>>s, pos = j & (span-1).
  - `rd_addr_a` = grp*2*span + pos; `rd_addr_b` = `rd_addr_a` + span.
  - `tw_addr` = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
- **Input order:** input data is bit-reversed; output is natural order. Not this block's concern beyond the addressing above.
- **Write-back pipeline:** a BF_LAT-deep shift register of {valid, addr_a, addr_b}.
  - It shifts every cycle regardless of `hold` or state.
  - Its output drives `wr_en`, `wr_addr_a` and `wr_addr_b`.
- **Start conditions:**
  - `start` in RUN, DRAIN or DONE is ignored. It is not queued.
  - `start` held high across DONE→IDLE begins a new transform on the IDLE cycle.
- **Reset** (async, any time): all registers, including the write pipe, clear immediately. Any in-flight transform is abandoned with no further `wr_en`.
- **Reset values:** all outputs 0, state IDLE.

## Timing
- All outputs are registered.
- Cycle numbering: cycle 0 is the edge that samples `start` in IDLE.
- The `rd_*` outputs for the first butterfly are valid in cycle 1.
- `wr_en` for the butterfly issued in cycle t is asserted in cycle t+BF_LAT, with the same addresses.
- `stage` changes in the same cycle as the first `rd_valid` of the new stage.
- DRAIN lasts exactly BF_LAT cycles when no hold is applied during the last issue.
- With `hold`=0 throughout, each stage takes N/2 + BF_LAT cycles.
- Defaults, no hold:
  - `rd_valid` in cycles 1-8, 11-18, 21-28, 31-38.
  - `wr_en` in cycles 3-10, 13-20, 23-30, 33-40.
  - `done` in cycle 41.
  - `busy` in cycles 1-41.
  - IDLE in cycle 42.
- `hold` adds exactly one cycle per held RUN cycle. `hold` during DRAIN or DONE has no effect.

## Test plan
- **Reset:** assert `reset_n`=0 mid-stage 2 with writes in flight → next cycle, all outputs 0 and no `wr_en`. After release plus `start`, the full normal sequence follows.
- **Nominal run** (defaults, `hold`=0): check the cycle windows listed under Timing and these spot addresses:
  - s0 j0 → a=0, b=1, tw=0.
  - s1 j1 → a=1, b=3, tw=4.
  - s2 j6 → a=10, b=14, tw=4.
  - s3 j5 → a=5, b=13, tw=5.
- **Hold:** `hold`=1 for cycles 4-6 of stage 0 → `rd_valid` gaps at 4-6, j resumes at 3 in cycle 7, and `done` moves to cycle 44.
- **Ignored start:** pulse `start` in cycles 5, 20 and 41 → no restart and a single `done` at 41. With `start` held high from cycle 41, the second transform's `rd_valid` begins at cycle 43.
- **BF_LAT=1 and BF_LAT=8:** `wr_en` trails `rd_valid` by exactly BF_LAT. Stage s+1's first read never occurs before stage s's last write; `done` at 4*(8+BF_LAT)+1.
- **Hold on the last issue:** `hold` asserted while j=7 is pending → DRAIN is entered only after j=7 issues, and its write lands BF_LAT cycles later.
